// File: rtl/producer2riscv.sv
// producer2riscv
//   Input-side stream buffer between an upstream producer and the picorv_mem
//   stream input port. A first-word-fall-through FIFO absorbs producer bursts
//   while the core polls its input port over the memory bus.
//
// Handshake (both sides): a word moves on a rising clk edge where the
//   sender's valid and the receiver's ready are both 1. The sender holds its
//   valid and data steady until that edge. The receiver may change ready at
//   any time.
//   Upstream:   push = val_in & ready_upward
//   Downstream: pop  = val_out & ready_downward
//
// Parameters
//   DATA_WIDTH  payload width in bits (default 32)
//   DEPTH       FIFO entries, a power of two >= 2 (default 8)
//   ADDR_W      derived pointer index width, $clog2(DEPTH)
//
// Ports
//   clk             in   rising-edge clock
//   reset           in   asynchronous active-high reset, synchronous release
//   din             in   upstream payload
//   val_in          in   upstream valid
//   ready_upward    out  registered accept indication to the producer
//   dout            out  FIFO head payload; 0 when val_out is 0
//   val_out         out  FIFO head valid
//   ready_downward  in   picorv_mem consumes the head this cycle
//   fill_level      out  registered occupancy, 0..DEPTH
//   word_cnt        out  pushes accepted, wraps          (P2R_STATS_EN only)
//   stall_cnt       out  cycles val_in=1 & ready_upward=0 (P2R_STATS_EN only)
//
// Configuration
//   P2R_STATS_EN  when defined, adds the word_cnt/stall_cnt statistics
//                 outputs. When undefined, those ports and counters are absent
//                 and the FIFO behaves identically.

module producer2riscv #(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 8,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  val_in,
    output logic                  ready_upward,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  val_out,
    input  logic                  ready_downward,
    output logic [ADDR_W:0]       fill_level
`ifdef P2R_STATS_EN
    ,
    output logic [31:0]           word_cnt,
    output logic [31:0]           stall_cnt
`endif
);

    localparam logic [ADDR_W:0] FILL_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] FILL_FULL = (ADDR_W+1)'(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ADDR_W:0]       wr_ptr;
    logic [ADDR_W:0]       rd_ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic            empty;
    logic            full;
    logic            push;
    logic            pop;
    logic [ADDR_W:0] fill_next;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

    // ready_upward is already 0 when full. The extra full term keeps a write
    // from ever overrunning the head, even if ready and occupancy disagree.
    assign push = val_in & ready_upward & ~full;
    assign pop  = val_out & ready_downward;

    always_comb begin
        fill_next = fill_level;
        case ({push, pop})
            2'b10:   fill_next = fill_level + FILL_ONE;
            2'b01:   fill_next = fill_level - FILL_ONE;
            default: fill_next = fill_level;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fill_level   <= '0;
            ready_upward <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + FILL_ONE;
            if (pop)  rd_ptr <= rd_ptr + FILL_ONE;
            fill_level <= fill_next;
            // The ready for the coming cycle comes from the occupancy that
            // takes effect after this edge. A push+pop at DEPTH-1 keeps it 1.
            ready_upward <= (fill_next < FILL_FULL);
        end
    end

    // Storage needs no reset: dout is forced to 0 whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[ADDR_W-1:0]] <= din;
    end

    // The head comes straight from registers. There is no bypass, so a word
    // written at one edge first appears on dout after that edge.
    assign val_out = ~empty;
    assign dout    = val_out ? mem[rd_ptr[ADDR_W-1:0]] : '0;

`ifdef P2R_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_cnt  <= 32'd0;
            stall_cnt <= 32'd0;
        end else begin
            if (push)                  word_cnt  <= word_cnt + 32'd1;
            if (val_in & ~ready_upward) stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
